// File: rtl/ycbcr_y_matrix3x3.sv
// ycbcr_y_matrix3x3: builds a zero-padded 3x3 window of Y samples from a vsync/href/Y stream
//   clk, rst_n               : clock, synchronous active-low reset
//   per_img_vsync/href/Y     : input frame valid, line valid, 8-bit luma
//   matrix_img_vsync/href    : input vsync/href delayed 2 cycles
//   matrix_p11..matrix_p33   : window rows r-2, r-1, r; columns c-2, c-1, c (p33 = current pixel)
module ycbcr_y_matrix3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_Y,
  output logic       matrix_img_vsync,
  output logic       matrix_img_href,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  if (IMG_WIDTH < 2 || IMG_HEIGHT < 1) begin : g_bad_params
    $error("ycbcr_y_matrix3x3: IMG_WIDTH must be >= 2 and IMG_HEIGHT >= 1");
  end
  logic [7:0]    r_buf0 [IMG_WIDTH];
  logic [7:0]    r_buf1 [IMG_WIDTH];
  logic [AW-1:0] r_col_cnt;
  logic [1:0]    r_row_cnt;
  logic          r_href1;
  logic          r_vsync1;
  logic [7:0]    r_y1;
  logic [7:0]    r_tap1;
  logic [7:0]    r_tap2;
  // Line RAMs are not reset; row_cnt masking hides stale contents.
  always_ff @(posedge clk) begin
    if (per_img_href) begin
      r_buf0[r_col_cnt] <= per_img_Y;
      r_buf1[r_col_cnt] <= r_buf0[r_col_cnt];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_href1   <= 1'b0;
      r_vsync1  <= 1'b0;
      r_y1      <= '0;
      r_tap1    <= '0;
      r_tap2    <= '0;
    end else begin
      r_href1   <= per_img_href;
      r_vsync1  <= per_img_vsync;
      r_y1      <= per_img_Y;
      r_tap1    <= (r_row_cnt == 2'd0) ? 8'd0 : r_buf0[r_col_cnt];
      r_tap2    <= r_row_cnt[1] ? r_buf1[r_col_cnt] : 8'd0;
      r_col_cnt <= !per_img_href ? '0 :
                   (r_col_cnt == AW'(IMG_WIDTH - 1)) ? r_col_cnt : r_col_cnt + 1'b1;
      // Low vsync or its rising edge (old vsync low) both restart the row count.
      r_row_cnt <= (!per_img_vsync || !r_vsync1) ? 2'd0 :
                   (r_href1 && !per_img_href && r_row_cnt != 2'd2) ? r_row_cnt + 2'd1 : r_row_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || !r_href1) begin
      matrix_p11 <= '0;
      matrix_p12 <= '0;
      matrix_p13 <= '0;
      matrix_p21 <= '0;
      matrix_p22 <= '0;
      matrix_p23 <= '0;
      matrix_p31 <= '0;
      matrix_p32 <= '0;
      matrix_p33 <= '0;
    end else begin
      matrix_p11 <= matrix_p12;
      matrix_p12 <= matrix_p13;
      matrix_p13 <= r_tap2;
      matrix_p21 <= matrix_p22;
      matrix_p22 <= matrix_p23;
      matrix_p23 <= r_tap1;
      matrix_p31 <= matrix_p32;
      matrix_p32 <= matrix_p33;
      matrix_p33 <= r_y1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix_img_href  <= 1'b0;
      matrix_img_vsync <= 1'b0;
    end else begin
      matrix_img_href  <= r_href1;
      matrix_img_vsync <= r_vsync1;
    end
  end
endmodule

// File: tb/tb_ycbcr_y_matrix3x3.sv
// tb_ycbcr_y_matrix3x3: random and patterned frames checked against a frame-array window model
module tb_ycbcr_y_matrix3x3;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic hr = 1'b0;
  logic [7:0] y = '0;
  logic o_vs, o_hr;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [71:0] w_taps;
  assign w_taps = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
  ycbcr_y_matrix3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vs), .per_img_href(hr), .per_img_Y(y),
    .matrix_img_vsync(o_vs), .matrix_img_href(o_hr),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] img [16][W];
  int row = 0;
  int col = 0;
  logic prev_hr = 1'b0;
  logic prev_vs = 1'b0;
  logic [73:0] d1 = '0;
  logic [73:0] d2 = '0;
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // One clock: drive inputs, compute the ideal window for this pixel, compare outputs two cycles late.
  task automatic tick(input logic v, input logic h, input logic [7:0] yy, input logic rn);
    logic [73:0] e;
    int r, c;
    vs = v; hr = h; y = yy; rst_n = rn;
    e = '0;
    if (rn) begin
      if (h) begin
        img[row][col] = yy;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            r = row - 2 + i;
            c = col - 2 + j;
            if (r >= 0 && c >= 0) e[(8 - (3 * i + j)) * 8 +: 8] = img[r][c];
          end
      end
      e[72] = h;
      e[73] = v;
      if (!v || !prev_vs) row = 0;
      else if (prev_hr && !h) row++;
      col = h ? ((col < W - 1) ? col + 1 : col) : 0;
      prev_hr = h;
      prev_vs = v;
    end else begin
      row = 0; col = 0; prev_hr = 1'b0; prev_vs = 1'b0;
    end
    @(posedge clk);
    d2 = d1;
    d1 = e;
    if (!rn) begin d1 = '0; d2 = '0; end
    @(negedge clk);
    check("vsync", 72'(o_vs), 72'(d2[73]));
    check("href", 72'(o_hr), 72'(d2[72]));
    check("window", w_taps, d2[71:0]);
  endtask
  // mode 0: Y=16*row+col, 1: all 0xFF, 2: random with random gaps; reset pulse at (rst_row, col 3)
  task automatic frame(input int rows, input int mode, input int rst_row);
    logic [7:0] yy;
    tick(1'b1, 1'b0, 8'd0, 1'b1);
    tick(1'b1, 1'b0, 8'd0, 1'b1);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        yy = (mode == 0) ? 8'(16 * r + c) : (mode == 1) ? 8'hFF : 8'($urandom);
        if (r == rst_row && c == 3) begin
          tick(1'b1, 1'b1, yy, 1'b0);
          return;
        end
        tick(1'b1, 1'b1, yy, 1'b1);
      end
      repeat ((mode == 2) ? $urandom_range(1, 6) : 5) tick(1'b1, 1'b0, 8'd0, 1'b1);
    end
    tick(1'b0, 1'b0, 8'd0, 1'b1);
  endtask
  initial begin
    repeat (50) tick(1'b0, 1'b0, 8'd0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 8'd0, 1'b1);
    frame(4, 0, -1);
    frame(4, 1, -1);
    frame(6, 2, 2);
    repeat (3) tick(1'b0, 1'b0, 8'd0, 1'b1);
    frame(5, 2, -1);
    for (int k = 0; k < 6; k++) frame($urandom_range(1, 12), 2, -1);
    repeat (4) tick(1'b0, 1'b0, 8'd0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ycbcr_y_matrix3x3.md
Name: ycbcr_y_matrix3x3

Overview:
- Downstream stage of the RGB888-to-YCbCr444 converter.
- Consumes its vsync/href/Y stream and produces, for every input pixel, a 3x3 window of Y samples.
- The window is built from two line buffers and column shift registers. Missing rows and columns at the image edges are zero-padded.
- Feeds the team's 3x3 filter stages (Sobel, median, mean).

Parameters:
IMG_WIDTH, 512, active pixels per line; sets line-buffer depth.
IMG_HEIGHT, 512, lines per frame; documentation only, not used by logic.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
per_img_vsync  in  1  frame valid; high for whole frame
per_img_href  in  1  line valid; one pulse of IMG_WIDTH cycles per line
per_img_Y  in  8  luma sample, valid when per_img_href=1
matrix_img_vsync  out  1  per_img_vsync delayed 2 cycles
matrix_img_href  out  1  per_img_href delayed 2 cycles
matrix_p11..matrix_p13  out  8 each  top row of window (line r-2), columns c-2, c-1, c
matrix_p21..matrix_p23  out  8 each  middle row (line r-1), columns c-2, c-1, c
matrix_p31..matrix_p33  out  8 each  bottom row (line r), columns c-2, c-1, c; p33 = current pixel

Behaviour:
- Reset (rst_n=0 at posedge clk): all outputs 0; col_cnt=0; row_cnt=0; shift registers 0. Line-buffer RAM contents need not be cleared.
- col_cnt:
  - Increments on each cycle with per_img_href=1.
  - Returns to 0 on the cycle after href falls.
  - Saturates at IMG_WIDTH-1; extra pixels reuse the last address.
- row_cnt:
  - Increments on each falling edge of per_img_href and saturates at 2.
  - Cleared while per_img_vsync=0.
  - Cleared on a vsync rising edge, so a new frame restarts even without a low period in between.
- Line buffers:
  - Two buffers, each IMG_WIDTH x 8 bits, addressed by col_cnt.
  - On each href cycle, buf1[col] is read to form tap r-2 and buf0[col] is read to form tap r-1.
  - In the same cycle, buf1[col] is written with the old buf0[col] and buf0[col] is written with per_img_Y (read-before-write).
- Row padding (stage 1): tap r-1 is forced to 0 when row_cnt=0; tap r-2 is forced to 0 when row_cnt<2.
- Column taps (stage 2):
  - Three 3-deep shift registers, one per row, shift on each delayed href=1 cycle: p?1<=p?2, p?2<=p?3, p?3<=tap.
  - When the delayed href=0, all nine registers clear to 0. The first pixel of every line therefore sees p?1=p?2=0 and the second sees p?1=0.
- Latency:
  - Exactly 2 clk from per_img_href/per_img_Y to matrix_img_href/p33.
  - vsync uses the same 2-cycle delay.
  - The matrix outputs are meaningful only while matrix_img_href=1; while it is 0 they are 0.
- Throughput: one pixel per clock, no backpressure, and no gaps are required inside href.
- Height is not checked; lines beyond IMG_HEIGHT are processed normally.
- Boundary conditions:
  - href shorter than IMG_WIDTH: the unused tail of the buffer keeps stale data, which is used only if a later line is longer.
  - vsync falling mid-line: row_cnt clears; the current line finishes normally through the pipeline.
  - Reset mid-frame: pipeline outputs go to 0 next cycle. The first frame after reset is padded correctly because row_cnt=0 masks the stale RAM contents.

Test Plan:
- Reset hold 50 cycles, then idle -> all 11 outputs 0; matrix_img_href=0 throughout.
- Override IMG_WIDTH=8; one frame of 4 lines with Y=16*row+col, rows and columns counted from 0; 5-cycle gap between lines.
  - Row 0, col 0: window all 0 except p33=0x00.
  - Row 0, col 3: p31=0x01, p32=0x02, p33=0x03; p1x=p2x=0.
- Same frame, row 2, col 5 -> p11..p13=03,04,05; p21..p23=13,14,15; p31..p33=23,24,25.
- Same frame, row 3, col 0 -> p11=p12=p21=p22=p31=p32=0; p13=0x10, p23=0x20, p33=0x30.
- Latency: href rising at cycle T -> matrix_img_href rises at T+2 and falls exactly 2 cycles after input href falls. vsync edges are likewise shifted by 2 cycles.
- Two back-to-back frames with the second frame using Y=0xFF everywhere -> second frame row 0 has p1x=p2x=0 (no leakage from frame 1). Row 2, col>=2 has all nine taps 0xFF.
- Assert rst_n=0 for 1 cycle mid-line 2 -> outputs 0 the next cycle. Next frame row 0, col 2 gives p31..p33 equal to that frame's first three pixels and all other taps 0.
- Full 512x512 frame, Y checked against a software model of the window built from the converter's reference Y output -> zero mismatches.
